// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types and frame arithmetic for the UART transmit path (UART_TX_PARITY_EN adds the parity bit)
package uart_pkg;

  // Transmit sequencer states; PARITY is only entered when UART_TX_PARITY_EN is defined.
  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_t;

  // Default number of clk cycles per UART bit.
  localparam int unsigned DEFAULT_DIV_MAX_VAL = 16;

  // Cycles from the cycle after accept up to and including the last stop-bit cycle.
  function automatic int unsigned frame_cycles(input int unsigned div_max_val,
                                               input int unsigned data_bits,
                                               input int unsigned stop_bits,
                                               input int unsigned parity_en);
    return (1 + data_bits + parity_en + stop_bits) * div_max_val;
  endfunction

endpackage

// File: rtl/uart_clk_div.sv
// rtl/uart_clk_div.sv - bit-period divider producing one mark per DivMaxVal enabled cycles
module uart_clk_div #(
  parameter int unsigned DivMaxVal  = 16,
  parameter int unsigned DivMarkPos = DivMaxVal - 1
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic clear_i,
  input  logic enable_i,
  output logic mark_o
);

  localparam int unsigned CntW = $clog2(DivMaxVal) + 1;
  localparam logic [CntW-1:0] CntMax  = CntW'(DivMaxVal - 1);
  localparam logic [CntW-1:0] MarkPos = CntW'(DivMarkPos);

  logic [CntW-1:0] cnt_q;

  // Free-running modulo-DivMaxVal count; clear wins so a frame starts at phase zero.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cnt_q <= '0;
    end else if (clear_i) begin
      cnt_q <= '0;
    end else if (enable_i) begin
      if (cnt_q == CntMax) begin
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_q + CntW'(1);
      end
    end
  end

  // The mark is high during the last cycle of a bit so the consumer moves on the boundary edge.
  assign mark_o = enable_i & ~clear_i & (cnt_q == MarkPos);

endmodule

// File: rtl/uart_tx_sequencer.sv
// rtl/uart_tx_sequencer.sv - UART frame sequencer: start, LSB-first data, optional parity (UART_TX_PARITY_EN), stop
module uart_tx_sequencer
  import uart_pkg::*;
#(
  parameter int unsigned DivMaxVal = DEFAULT_DIV_MAX_VAL,
  parameter int unsigned DataBits  = 8,
  parameter int unsigned StopBits  = 1
) (
  input  logic                clk_i,
  input  logic                rst_n_i,
  input  logic [DataBits-1:0] data_i,
  input  logic                valid_i,
`ifdef UART_TX_PARITY_EN
  input  logic                parity_odd_i,
`endif
  output logic                ready_o,
  output logic                tx_o,
  output logic                busy_o,
  output logic                done_o
);

  localparam int unsigned BitCntW = $clog2(DataBits) + 1;
  localparam logic [BitCntW-1:0] LastData = BitCntW'(DataBits - 1);
  localparam logic [BitCntW-1:0] LastStop = BitCntW'(StopBits - 1);

  tx_state_t           state_q;
  logic [DataBits-1:0] shift_q;
  logic [BitCntW-1:0]  bit_cnt_q;
  logic                tx_q;
  logic                ready_q;
  logic                busy_q;
  logic                done_q;
  logic                bit_mark;
`ifdef UART_TX_PARITY_EN
  logic                parity_q;
`endif

  uart_clk_div #(
    .DivMaxVal (DivMaxVal),
    .DivMarkPos(DivMaxVal - 1)
  ) u_clk_div (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .clear_i (state_q == IDLE),
    .enable_i(1'b1),
    .mark_o  (bit_mark)
  );

  // Frame FSM with registered line and handshake outputs; every bit change happens on a divider mark.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      tx_q      <= 1'b1;
      ready_q   <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_q  <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (valid_i && ready_q) begin
            state_q   <= START;
            shift_q   <= data_i;
            bit_cnt_q <= '0;
            tx_q      <= 1'b0;
            ready_q   <= 1'b0;
            busy_q    <= 1'b1;
`ifdef UART_TX_PARITY_EN
            parity_q  <= (^data_i) ^ parity_odd_i;
`endif
          end
        end
        START: begin
          if (bit_mark) begin
            state_q   <= DATA;
            tx_q      <= shift_q[0];
            shift_q   <= shift_q >> 1;
            bit_cnt_q <= '0;
          end
        end
        DATA: begin
          if (bit_mark) begin
            if (bit_cnt_q == LastData) begin
              bit_cnt_q <= '0;
`ifdef UART_TX_PARITY_EN
              state_q   <= PARITY;
              tx_q      <= parity_q;
`else
              state_q   <= STOP;
              tx_q      <= 1'b1;
`endif
            end else begin
              tx_q      <= shift_q[0];
              shift_q   <= shift_q >> 1;
              bit_cnt_q <= bit_cnt_q + BitCntW'(1);
            end
          end
        end
`ifdef UART_TX_PARITY_EN
        PARITY: begin
          if (bit_mark) begin
            state_q   <= STOP;
            tx_q      <= 1'b1;
            bit_cnt_q <= '0;
          end
        end
`endif
        STOP: begin
          if (bit_mark) begin
            if (bit_cnt_q == LastStop) begin
              state_q   <= IDLE;
              bit_cnt_q <= '0;
              ready_q   <= 1'b1;
              busy_q    <= 1'b0;
              done_q    <= 1'b1;
            end else begin
              bit_cnt_q <= bit_cnt_q + BitCntW'(1);
            end
          end
        end
        default: begin
          state_q   <= IDLE;
          bit_cnt_q <= '0;
          tx_q      <= 1'b1;
          ready_q   <= 1'b1;
          busy_q    <= 1'b0;
        end
      endcase
    end
  end

  assign ready_o = ready_q;
  assign tx_o    = tx_q;
  assign busy_o  = busy_q;
  assign done_o  = done_q;

endmodule

// File: tb/tb_uart_tx_sequencer.sv
// tb/tb_uart_tx_sequencer.sv - randomized bench for uart_tx_sequencer against a bit-list frame model (UART_TX_PARITY_EN aware)
module tb_uart_tx_sequencer;

  localparam int DIV = 4;
`ifdef UART_TX_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  localparam int MODE_QUIET = 0;
  localparam int MODE_PULSE = 1;
  localparam int MODE_HOLD  = 2;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] data1, data2;
  logic       valid1, valid2;
  logic       ready1, tx1, busy1, done1;
  logic       ready2, tx2, busy2, done2;
`ifdef UART_TX_PARITY_EN
  logic       parity_odd;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  uart_tx_sequencer #(.DivMaxVal(DIV), .DataBits(8), .StopBits(1)) dut1 (
    .clk_i       (clk),
    .rst_n_i     (rst_n),
    .data_i      (data1),
    .valid_i     (valid1),
`ifdef UART_TX_PARITY_EN
    .parity_odd_i(parity_odd),
`endif
    .ready_o     (ready1),
    .tx_o        (tx1),
    .busy_o      (busy1),
    .done_o      (done1)
  );

  uart_tx_sequencer #(.DivMaxVal(DIV), .DataBits(8), .StopBits(2)) dut2 (
    .clk_i       (clk),
    .rst_n_i     (rst_n),
    .data_i      (data2),
    .valid_i     (valid2),
`ifdef UART_TX_PARITY_EN
    .parity_odd_i(parity_odd),
`endif
    .ready_o     (ready2),
    .tx_o        (tx2),
    .busy_o      (busy2),
    .done_o      (done2)
  );

  task automatic check(input string tag, input logic got, input logic exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  function automatic logic get_tx(input int sel);    return (sel == 1) ? tx1 : tx2;       endfunction
  function automatic logic get_ready(input int sel); return (sel == 1) ? ready1 : ready2; endfunction
  function automatic logic get_busy(input int sel);  return (sel == 1) ? busy1 : busy2;   endfunction
  function automatic logic get_done(input int sel);  return (sel == 1) ? done1 : done2;   endfunction

  task automatic drive(input int sel, input logic v, input logic [7:0] d);
    if (sel == 1) begin
      valid1 = v;
      data1  = d;
    end else begin
      valid2 = v;
      data2  = d;
    end
  endtask

  task automatic check_idle(input int sel, input string tag);
    check($sformatf("%s tx%0d", tag, sel), get_tx(sel), 1'b1);
    check($sformatf("%s ready%0d", tag, sel), get_ready(sel), 1'b1);
    check($sformatf("%s busy%0d", tag, sel), get_busy(sel), 1'b0);
    check($sformatf("%s done%0d", tag, sel), get_done(sel), 1'b0);
  endtask

  task automatic idle(input int sel, input int k);
    for (int i = 0; i < k; i++) begin
      @(negedge clk);
      check_idle(sel, "idle");
    end
  endtask

  // Called at a negedge with valid/data already presented; returns at the negedge of the done cycle
  // after presenting the next word (nv/nd).
  task automatic frame(input int sel, input int mode, input logic [7:0] noise_d,
                       input logic nv, input logic [7:0] nd);
    logic [7:0] d;
    int         stop_bits;
    int         n;
    int         pc;
    bit         q[$];
    d         = (sel == 1) ? data1 : data2;
    stop_bits = (sel == 1) ? 1 : 2;
    q.push_back(1'b0);
    for (int i = 0; i < 8; i++) q.push_back(d[i]);
`ifdef UART_TX_PARITY_EN
    q.push_back((($countones(d) % 2) == 1) ^ parity_odd);
`endif
    for (int s = 0; s < stop_bits; s++) q.push_back(1'b1);
    n  = q.size() * DIV;
    pc = $urandom_range(2, n - 2);
    check($sformatf("ready before accept %0d", sel), get_ready(sel), 1'b1);
    @(posedge clk);
    for (int c = 1; c <= n; c++) begin
      @(negedge clk);
      case (mode)
        MODE_HOLD:  drive(sel, 1'b1, 8'($urandom));
        MODE_PULSE: drive(sel, c == pc, (c == pc) ? noise_d : 8'($urandom));
        default:    drive(sel, 1'b0, 8'($urandom));
      endcase
      check($sformatf("tx%0d d=%02h c%0d", sel, d, c), get_tx(sel), q[(c - 1) / DIV]);
      check($sformatf("busy%0d c%0d", sel, c), get_busy(sel), 1'b1);
      check($sformatf("ready%0d c%0d", sel, c), get_ready(sel), 1'b0);
      check($sformatf("done%0d c%0d", sel, c), get_done(sel), 1'b0);
    end
    @(negedge clk);
    check($sformatf("done pulse%0d d=%02h", sel, d), get_done(sel), 1'b1);
    check($sformatf("ready at done%0d", sel), get_ready(sel), 1'b1);
    check($sformatf("busy at done%0d", sel), get_busy(sel), 1'b0);
    check($sformatf("tx at done%0d", sel), get_tx(sel), 1'b1);
    drive(sel, nv, nd);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int         sel;
    int         mode;
    logic       nv;
    logic       pending;
    logic [7:0] d;

    rst_n  = 1'b0;
    valid1 = 1'b0;
    valid2 = 1'b0;
    data1  = 8'h00;
    data2  = 8'h00;
`ifdef UART_TX_PARITY_EN
    parity_odd = 1'b0;
`endif
    repeat (3) @(negedge clk);
    check_idle(1, "reset");
    check_idle(2, "reset");
    rst_n = 1'b1;
    idle(1, 20);

    // single frame 0xA5
    drive(1, 1'b1, 8'hA5);
    frame(1, MODE_QUIET, 8'h00, 1'b0, 8'h00);
    idle(1, 2);

    // back-to-back 0x00 then 0xFF with valid held high
    drive(1, 1'b1, 8'h00);
    frame(1, MODE_HOLD, 8'h00, 1'b1, 8'hFF);
    frame(1, MODE_HOLD, 8'h00, 1'b0, 8'h00);
    idle(1, 2);

    // valid pulse with 0x3C while busy is ignored
    drive(1, 1'b1, 8'h5A);
    frame(1, MODE_PULSE, 8'h3C, 1'b0, 8'h00);
    idle(1, 2);

    // two stop bits
    drive(2, 1'b1, 8'hC3);
    frame(2, MODE_PULSE, 8'h3C, 1'b0, 8'h00);
    idle(2, 2);

`ifdef UART_TX_PARITY_EN
    parity_odd = 1'b0;
    drive(1, 1'b1, 8'h07);
    frame(1, MODE_QUIET, 8'h00, 1'b0, 8'h00);
    idle(1, 2);
    parity_odd = 1'b1;
    drive(1, 1'b1, 8'h07);
    frame(1, MODE_QUIET, 8'h00, 1'b0, 8'h00);
    idle(1, 2);
`endif

    // randomized frames across both stop-bit configurations, with random chaining
    pending = 1'b0;
    sel     = 1;
    for (int i = 0; i < 16; i++) begin
      if (!pending) begin
        sel = $urandom_range(1, 2);
`ifdef UART_TX_PARITY_EN
        parity_odd = 1'($urandom_range(0, 1));
`endif
        drive(sel, 1'b1, 8'($urandom));
      end
      mode = $urandom_range(0, 2);
      nv   = (i < 15) ? 1'($urandom_range(0, 1)) : 1'b0;
      frame(sel, mode, 8'($urandom), nv, 8'($urandom));
      pending = nv;
      if (!nv) idle(sel, $urandom_range(1, 3));
    end

    // reset during data bit 3 aborts the frame at once
    d = 8'($urandom);
    drive(1, 1'b1, d);
    @(posedge clk);
    @(negedge clk);
    drive(1, 1'b0, 8'h00);
    repeat (4 * DIV) @(negedge clk);
    check("tx before reset bit3", tx1, d[3]);
    check("busy before reset", busy1, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check_idle(1, "async reset");
    @(negedge clk);
    check_idle(1, "in reset");
    rst_n = 1'b1;
    idle(1, 3);
    drive(1, 1'b1, 8'($urandom));
    frame(1, MODE_QUIET, 8'h00, 1'b0, 8'h00);
    idle(1, 2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
